toggle_monitor: RTL and testbench
=================================

// Module: toggle_monitor
// PURPOSE
//  Downstream consumer of the T-trigger Q output. Synchronises the asynchronous
//  toggle level into clk, emits one-cycle rise/fall strobes, counts edges,
//  measures the Q period in clk cycles and flags threshold and overflow events.
//  Sits between the T-trigger stage and any control/readout logic.
// PARAMETERS
//  CNT_W        16  width of edge counter and threshold
//  PER_W        16  width of period counter/measurement
//  SYNC_STAGES  2   synchroniser depth (>=2)
//  FILT_LEN     4   glitch-filter length in clk cycles (GLITCH_FILTER_EN only)
// PORTS
//  clk         in   1      single system clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  q_in        in   1      asynchronous toggle level from T-trigger Q
//  clr         in   1      synchronous clear of counts/flags/FSM
//  thr         in   CNT_W  edge-count threshold; 0 disables thr_hit
//  q_sync      out  1      synchronised (optionally filtered) q_in
//  rise        out  1      1-cycle strobe on q_sync 0->1
//  fall        out  1      1-cycle strobe on q_sync 1->0
//  edge_cnt    out  CNT_W  number of edges since rst/clr, wraps
//  period      out  PER_W  clk cycles between last two rising edges
//  period_vld  out  1      1-cycle strobe when period updates
//  thr_hit     out  1      sticky: edge_cnt reached thr
//  per_ovf     out  1      sticky: period counter saturated
// BEHAVIOUR
//  - rst asserted: all outputs 0, sync flops 0, FSM=IDLE, immediately (async).
//  - Sync chain of SYNC_STAGES flops; q_sync = last stage; q_in->q_sync 2-3 clk.
//  - q_d = q_sync delayed 1 clk; rise/fall registered, high 1 clk after q_sync changes.
//  - edge_cnt +1 on every rise or fall; 2^CNT_W-1 wraps to 0, no flag.
//  - thr_hit sets in the cycle edge_cnt becomes == thr (thr!=0); held until clr/rst.
//  - FSM IDLE: per_cnt=0; on rise -> RUN, per_cnt=1.
//  - FSM RUN: per_cnt +1 each clk; on rise: period<=per_cnt, period_vld=1, per_cnt<=1.
//    per_cnt reaching 2^PER_W-1 without rise: per_ovf=1, -> IDLE, no period_vld.
//  - clr: edge_cnt, period, per_cnt, thr_hit, per_ovf <= 0, FSM -> IDLE.
//    clr wins over simultaneous edge: edge not counted, no period_vld;
//    rise/fall strobes and q_sync unaffected by clr.
//  - period_vld and rise coincide in the same cycle; first rise after IDLE gives none.
// CONFIGURATION
//  GLITCH_FILTER_EN defined: filter after sync chain; q_sync updates only after
//   FILT_LEN consecutive equal samples; adds FILT_LEN clk latency; shorter pulses dropped.
//  Not defined: q_sync = sync chain output directly; FILT_LEN unused.
// STRUCTURE
//  Package toggle_pkg: FSM state encoding (IDLE=1'b0, RUN=1'b1), default widths.
//  Sub-module sync_chain (SYNC_STAGES param, async rst) instantiated once;
//  edge detect, counters, FSM and filter stay in toggle_monitor.
// TESTING (clk 10 ns)
//  1 rst=1 while q_in toggles -> all outputs 0; release, q_in 0->1 -> rise within 3 clk.
//  2 q_in toggles every 5 clk -> alternating rise/fall, edge_cnt +1 per edge,
//    period=10 with period_vld from 2nd rise onward.
//  3 thr=6, same stimulus -> thr_hit=1 cycle edge_cnt=6, stays; clr -> thr_hit=0, edge_cnt=0.
//  4 PER_W=4, q_in high/low 20 clk -> per_ovf=1, FSM IDLE; next two rises -> one period_vld.
//  5 clr in same cycle as rise -> rise=1, edge_cnt=0, period_vld=0.
//  6 CNT_W=3, 8 edges -> edge_cnt=0; with GLITCH_FILTER_EN, 2-clk q_in pulse -> no strobe.

Source files
------------

// File: rtl/toggle_pkg.sv
// Shared constants for the toggle monitor: FSM state encoding and default widths.
package toggle_pkg;
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_PER_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_LEN    = 4;
endpackage

// File: rtl/toggle_monitor_sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_chain
  import toggle_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] stg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stg <= '0;
    else     stg <= {stg[SYNC_STAGES-2:0], d};
  end

  assign q = stg[SYNC_STAGES-1];
endmodule

// File: rtl/toggle_monitor.sv
// Toggle monitor: sync, edge strobes, edge count, Q period and threshold/overflow flags.
// Optional glitch filter after the synchroniser is enabled by defining GLITCH_FILTER_EN.
module toggle_monitor
  import toggle_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PER_W       = DEF_PER_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_LEN    = DEF_FILT_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             clr,
  input  logic [CNT_W-1:0] thr,
  output logic             q_sync,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [PER_W-1:0] period,
  output logic             period_vld,
  output logic             thr_hit,
  output logic             per_ovf
);
  localparam logic [PER_W-1:0] PER_MAX = '1;

  logic             sync_out;
  logic             q_d;
  logic             rise_c;
  logic             fall_c;
  logic             state;
  logic [PER_W-1:0] per_cnt;
  logic [CNT_W-1:0] cnt_nx;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (q_in),
    .q   (sync_out)
  );

`ifdef GLITCH_FILTER_EN
  localparam int FC_W = $clog2(FILT_LEN + 1);
  logic [FC_W-1:0] filt_cnt;
  logic            filt_q;

  // Output follows the input only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt <= '0;
      filt_q   <= 1'b0;
    end else if (sync_out == filt_q) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
      filt_q   <= sync_out;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign q_sync = filt_q;
`else
  logic filt_unused;
  assign filt_unused = (FILT_LEN != 0);
  assign q_sync      = sync_out;
`endif

  assign rise_c = q_sync & ~q_d;
  assign fall_c = ~q_sync & q_d;
  assign cnt_nx = edge_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_d  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      q_d  <= q_sync;
      rise <= rise_c;
      fall <= fall_c;
    end
  end

  // Counter and flags update on the same edge the strobe is registered, so they line up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      thr_hit  <= 1'b0;
    end else if (clr) begin
      edge_cnt <= '0;
      thr_hit  <= 1'b0;
    end else if (rise_c || fall_c) begin
      edge_cnt <= cnt_nx;
      if ((thr != '0) && (cnt_nx == thr)) thr_hit <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      per_cnt    <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      per_ovf    <= 1'b0;
    end else begin
      period_vld <= 1'b0;
      if (clr) begin
        state   <= IDLE;
        per_cnt <= '0;
        period  <= '0;
        per_ovf <= 1'b0;
      end else if (state == RUN) begin
        if (rise_c) begin
          period     <= per_cnt;
          period_vld <= 1'b1;
          per_cnt    <= PER_W'(1);
        end else if (per_cnt == PER_MAX) begin
          // Period too long to measure: drop back and wait for a fresh rising edge.
          per_ovf <= 1'b1;
          state   <= IDLE;
          per_cnt <= '0;
        end else begin
          per_cnt <= per_cnt + 1'b1;
        end
      end else begin
        if (rise_c) begin
          state   <= RUN;
          per_cnt <= PER_W'(1);
        end else begin
          per_cnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_toggle_monitor.sv
// Scoreboard bench: a wide instance (A) and a narrow instance (B: CNT_W=3, PER_W=4) share stimulus.
module tb_toggle_monitor;
`ifdef GLITCH_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  typedef struct packed {
    logic        r;
    logic        f;
    logic        pv;
    logic        th;
    logic [15:0] cnt;
    logic [15:0] per;
  } exp_t;

  logic        clk, rst, q_in, clr;
  logic [15:0] thr;
  logic [2:0]  thr_b;
  logic        q_sync_a, rise_a, fall_a, pv_a, thr_hit_a, per_ovf_a;
  logic [15:0] edge_cnt_a, period_a;
  logic        q_sync_b, rise_b, fall_b, pv_b, thr_hit_b, per_ovf_b;
  logic [2:0]  edge_cnt_b;
  logic [3:0]  period_b;

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk, n_fail;
  int   cnt_a, cnt_b, gap;
  bit   run_a, run_b, th_a, q_lvl;
  logic [15:0] thr_val;

  toggle_monitor dut_a (
    .clk(clk), .rst(rst), .q_in(q_in), .clr(clr), .thr(thr),
    .q_sync(q_sync_a), .rise(rise_a), .fall(fall_a), .edge_cnt(edge_cnt_a),
    .period(period_a), .period_vld(pv_a), .thr_hit(thr_hit_a), .per_ovf(per_ovf_a)
  );

  toggle_monitor #(.CNT_W(3), .PER_W(4)) dut_b (
    .clk(clk), .rst(rst), .q_in(q_in), .clr(clr), .thr(thr_b),
    .q_sync(q_sync_b), .rise(rise_b), .fall(fall_b), .edge_cnt(edge_cnt_b),
    .period(period_b), .period_vld(pv_b), .thr_hit(thr_hit_b), .per_ovf(per_ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
    gap += n;
  endtask

  // Toggle q_in and queue the strobe each instance must report for it.
  task automatic issue(input bit with_clr);
    exp_t ea, eb;
    q_lvl = ~q_lvl;
    q_in  = q_lvl;
    ea = '0;
    ea.r = q_lvl;
    ea.f = ~q_lvl;
    eb = ea;
    if (with_clr) begin
      cnt_a = 0; cnt_b = 0; th_a = 0; run_a = 0; run_b = 0;
    end else begin
      cnt_a = (cnt_a + 1) % 65536;
      cnt_b = (cnt_b + 1) % 8;
      if (thr_val != 0 && cnt_a == int'(thr_val)) th_a = 1;
      if (q_lvl) begin
        ea.pv  = run_a;
        ea.per = 16'(gap);
        eb.pv  = run_b && (gap <= 15);
        eb.per = 16'(gap);
        run_a = 1;
        run_b = 1;
      end
    end
    if (q_lvl) gap = 0;
    ea.cnt = 16'(cnt_a);
    ea.th  = th_a;
    eb.cnt = 16'(cnt_b);
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  task automatic toggle(input int hold);
    issue(1'b0);
    wait_cyc(hold);
  endtask

  // Toggle with clr asserted in exactly the cycle the resulting strobe registers.
  task automatic toggle_clr(input int hold);
    issue(1'b1);
    wait_cyc(LAT - 1);
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    wait_cyc(hold - LAT);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    cnt_a = 0; cnt_b = 0; th_a = 0; run_a = 0; run_b = 0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rise_a || fall_a || pv_a) begin
        if (qa.size() == 0) chk("a_unexpected_strobe", {rise_a, fall_a, pv_a}, 3'b000);
        else begin
          e = qa.pop_front();
          chk("a_event", {rise_a, fall_a, pv_a, thr_hit_a, edge_cnt_a}, {e.r, e.f, e.pv, e.th, e.cnt});
          if (e.pv) chk("a_period", period_a, e.per);
        end
      end
      if (rise_b || fall_b || pv_b) begin
        if (qb.size() == 0) chk("b_unexpected_strobe", {rise_b, fall_b, pv_b}, 3'b000);
        else begin
          e = qb.pop_front();
          chk("b_event", {rise_b, fall_b, pv_b, thr_hit_b, edge_cnt_b}, {e.r, e.f, e.pv, 1'b0, e.cnt[2:0]});
          if (e.pv) chk("b_period", period_b, e.per[3:0]);
        end
      end
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    cnt_a = 0; cnt_b = 0; gap = 0; run_a = 0; run_b = 0; th_a = 0; q_lvl = 0;
    rst = 1'b1; q_in = 1'b0; clr = 1'b0; thr = '0; thr_b = '0; thr_val = '0;
    fork
      monitor();
      begin
        // Reset held while q_in toggles: everything stays zero.
        for (int i = 0; i < 8; i++) begin
          q_in = ~q_in;
          @(posedge clk);
          #1;
        end
        chk("reset_a", {q_sync_a, rise_a, fall_a, edge_cnt_a, period_a, pv_a, thr_hit_a, per_ovf_a}, '0);
        chk("reset_b", {q_sync_b, rise_b, fall_b, edge_cnt_b, period_b, pv_b, thr_hit_b, per_ovf_b}, '0);
        q_in = 1'b0;
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(2);

        // First rise: fixed latency, no period_vld.
        issue(1'b0);
        wait_cyc(LAT - 1);
        chk("rise_early", rise_a, 1'b0);
        wait_cyc(1);
        chk("rise_latency", rise_a, 1'b1);
        wait_cyc(10 - LAT);

        // Regular toggling every 5 clk: period 10 from the 2nd full cycle.
        for (int i = 0; i < 7; i++) toggle(5);
        toggle(10);

        // Threshold 6 from a cleared count.
        do_clr();
        chk("clr_cnt", edge_cnt_a, 16'd0);
        thr = 16'd6; thr_val = 16'd6;
        for (int i = 0; i < 9; i++) toggle(5);
        toggle(10);
        chk("thr_hit_sticky", thr_hit_a, 1'b1);
        do_clr();
        chk("clr_thr_hit", {thr_hit_a, edge_cnt_a}, 17'd0);
        thr = '0; thr_val = '0;

        // Long half-periods overflow the 4-bit period counter on B only.
        for (int i = 0; i < 3; i++) toggle(20);
        chk("ovf_b", per_ovf_b, 1'b1);
        chk("no_ovf_a", per_ovf_a, 1'b0);
        for (int i = 0; i < 5; i++) toggle(5);
        toggle(10);
        if (q_lvl) toggle(10);

        // clr coincident with a rise: strobe kept, count and period discarded.
        toggle_clr(10);
        chk("clr_rise_cnt", {edge_cnt_a, per_ovf_b}, 17'd0);
        for (int i = 0; i < 3; i++) toggle(5);
        toggle(10);

        // Eight edges wrap the 3-bit count of B.
        do_clr();
        for (int i = 0; i < 7; i++) toggle(5);
        toggle(10);
        chk("wrap_b", edge_cnt_b, 3'd0);
        chk("count_a", edge_cnt_a, 16'd8);
`ifdef GLITCH_FILTER_EN
        q_in = ~q_lvl;
        wait_cyc(2);
        q_in = q_lvl;
        wait_cyc(12);
        chk("glitch_dropped", {q_sync_a, edge_cnt_a}, {q_lvl, 16'd8});
`endif
        wait_cyc(LAT + 4);
        chk("queue_a_empty", qa.size(), 0);
        chk("queue_b_empty", qb.size(), 0);
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
